fir_stream_sequencer: RTL and testbench

- Wishbone-configured sequencer that feeds the FIR AXI-Stream input from a block of BRAM samples and writes the FIR AXI-Stream output back to BRAM.
- Sits between the user-area Wishbone decode, one shared BRAM port and the FIR ss/sm ports.
- Replaces per-sample CPU polling with a single start command.
- Owns arbitration of the single BRAM port between its sample-read side and its result-write side.

---
 rtl/fir_stream_sequencer.sv | 169 ++++++++++++++++
 tb/tb_fir_stream_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream_sequencer.sv
// rtl/fir_stream_sequencer.sv - Wishbone-configured sequencer moving BRAM samples through the FIR stream ports
module fir_stream_sequencer #(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 12
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [7:0]        wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              ss_tvalid,
    output logic [31:0]       ss_tdata,
    output logic              ss_tlast,
    input  logic              ss_tready,
    input  logic              sm_tvalid,
    input  logic [31:0]       sm_tdata,
    input  logic              sm_tlast,
    output logic              sm_tready,
    output logic              busy
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;
    state_t state_q, state_d;

    logic [LEN_W-1:0]  len_q, rd_cnt, wr_cnt, len_m1;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic              done_q, err_q;
    logic              rd_pend, rd_pend_last;
    logic              buf_valid, buf_last;
    logic [31:0]       buf_data;
    logic              wb_req, wb_wr, ctrl_wr, start, abort;
    logic              run, wr_fire, rd_issue;
    logic [31:0]       rd_mux;
    logic              unused_dat;

    assign unused_dat = &{1'b0, wbs_dat_i};

    // A request is taken only on the cycle before ack, so ack never repeats back to back
    assign wb_req  = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wb_wr   = wb_req & wbs_we_i;
    assign ctrl_wr = wb_wr && (wbs_adr_i == 8'h00);
    assign start   = ctrl_wr & wbs_dat_i[0];
    assign abort   = ctrl_wr & wbs_dat_i[4];

    assign run       = (state_q == S_RUN);
    assign busy      = (state_q != S_IDLE);
    assign len_m1    = len_q - 1'b1;
    assign sm_tready = run && (wr_cnt < len_q);
    assign wr_fire   = sm_tvalid && sm_tready;
    assign rd_issue  = run && (rd_cnt < len_q) && !rd_pend && !buf_valid && !wr_fire;
    assign ss_tvalid = run && buf_valid;
    assign ss_tdata  = buf_data;
    assign ss_tlast  = buf_last;

    // Single BRAM port: result writes always win, a blocked read simply retries
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'h0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (wr_fire) begin
            mem_en    = 1'b1;
            mem_we    = 4'hF;
            mem_addr  = dst_q + ADDR_W'(wr_cnt);
            mem_wdata = sm_tdata;
        end else if (rd_issue) begin
            mem_en   = 1'b1;
            mem_addr = src_q + ADDR_W'(rd_cnt);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = (len_q == '0) ? S_FINISH : S_RUN;
            S_RUN:    if (wr_cnt == len_q) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    always_comb begin
        rd_mux = '0;
        case (wbs_adr_i)
            8'h00:   rd_mux = {27'd0, 1'b0, err_q, (state_q == S_IDLE), done_q, 1'b0};
            8'h04:   rd_mux = 32'(len_q);
            8'h08:   rd_mux = 32'(src_q);
            8'h0C:   rd_mux = 32'(dst_q);
            8'h10:   rd_mux = 32'(wr_cnt);
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= S_IDLE;
            wbs_ack_o    <= 1'b0;
            wbs_dat_o    <= '0;
            len_q        <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rd_cnt       <= '0;
            wr_cnt       <= '0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
            buf_valid    <= 1'b0;
            buf_last     <= 1'b0;
            buf_data     <= '0;
        end else begin
            state_q   <= state_d;
            wbs_ack_o <= wb_req;
            wbs_dat_o <= (wb_req && !wbs_we_i) ? rd_mux : 32'd0;

            if (wb_wr && (state_q == S_IDLE)) begin
                case (wbs_adr_i)
                    8'h04:   len_q <= wbs_dat_i[LEN_W-1:0];
                    8'h08:   src_q <= wbs_dat_i[ADDR_W-1:0];
                    8'h0C:   dst_q <= wbs_dat_i[ADDR_W-1:0];
                    default: ;
                endcase
            end
            if (ctrl_wr && wbs_dat_i[1]) done_q <= 1'b0;
            if (ctrl_wr && wbs_dat_i[3]) err_q <= 1'b0;
            if ((state_q == S_FINISH) && !abort) done_q <= 1'b1;

            rd_pend <= rd_issue;
            if (rd_issue) begin
                rd_cnt       <= rd_cnt + 1'b1;
                rd_pend_last <= (rd_cnt == len_m1);
            end
            if (rd_pend) begin
                buf_valid <= 1'b1;
                buf_data  <= mem_rdata;
                buf_last  <= rd_pend_last;
            end else if (ss_tvalid && ss_tready) begin
                buf_valid <= 1'b0;
            end

            if (wr_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (sm_tlast != (wr_cnt == len_m1)) err_q <= 1'b1;
            end

            if ((state_q == S_IDLE) && start && !abort) begin
                rd_cnt    <= '0;
                wr_cnt    <= '0;
                rd_pend   <= 1'b0;
                buf_valid <= 1'b0;
                err_q     <= 1'b0;
            end
            // Abort discards an in-flight read so stale data never reaches the buffer
            if (abort) begin
                rd_pend   <= 1'b0;
                buf_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fir_stream_sequencer.sv
// tb/tb_fir_stream_sequencer.sv - directed self-checking bench for fir_stream_sequencer
module tb_fir_stream_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [7:0]  adr;
    logic [31:0] wdat;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        ss_tvalid, ss_tlast, ss_tready;
    logic [31:0] ss_tdata;
    logic        sm_tvalid, sm_tlast, sm_tready;
    logic [31:0] sm_tdata;
    logic        busy;

    always #5 clk = ~clk;

    fir_stream_sequencer dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_adr_i(adr),
        .wbs_dat_i(wdat),
        .wbs_ack_o(wbs_ack_o),
        .wbs_dat_o(wbs_dat_o),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .ss_tvalid(ss_tvalid),
        .ss_tdata (ss_tdata),
        .ss_tlast (ss_tlast),
        .ss_tready(ss_tready),
        .sm_tvalid(sm_tvalid),
        .sm_tdata (sm_tdata),
        .sm_tlast (sm_tlast),
        .sm_tready(sm_tready),
        .busy     (busy)
    );

    logic [31:0] bram [0:4095];
    logic [32:0] fir_q[$];
    logic [31:0] ss_log[$];
    logic        ss_last_log[$];
    logic [11:0] rd_addr_q[$];

    int total = 0;
    int bad = 0;
    int rd_seen = 0, wr_seen = 0, busy_cycles = 0, en_cnt = 0, ssv_cnt = 0;
    int wr_then_rd = 0, we_bad = 0, fire_bad = 0, ack_dbl = 0, dato_bad = 0;
    int stall_left = 0, stall_seen = 0, stall_bad = 0, stall_reads = 0, stall_gap = 0;
    logic stall_started = 1'b0;
    int res_idx = 0;
    int bad_idx = -1;

    // BRAM with one-cycle read latency plus FIR loopback (result = 2 * sample)
    initial begin : model
        logic        s_fire, m_fire, m_en, s_last, prev_wr, prev_ack;
        logic [3:0]  m_we;
        logic [11:0] m_addr;
        logic [31:0] m_wd, s_data;
        mem_rdata = '0;
        ss_tready = 1'b1;
        sm_tvalid = 1'b0;
        sm_tdata  = '0;
        sm_tlast  = 1'b0;
        prev_wr   = 1'b0;
        prev_ack  = 1'b0;
        forever begin
            @(negedge clk);
            s_fire = ss_tvalid & ss_tready;
            s_data = ss_tdata;
            s_last = ss_tlast;
            m_fire = sm_tvalid & sm_tready;
            m_en   = mem_en;
            m_we   = mem_we;
            m_addr = mem_addr;
            m_wd   = mem_wdata;
            if (busy) busy_cycles++;
            if (mem_en) en_cnt++;
            if (ss_tvalid) ssv_cnt++;
            if (mem_en && mem_we != 4'h0 && mem_we != 4'hF) we_bad++;
            if (m_fire && !(mem_en && mem_we == 4'hF && mem_wdata == sm_tdata)) fire_bad++;
            if (prev_wr && mem_en && mem_we == 4'h0) wr_then_rd++;
            prev_wr = mem_en && (mem_we == 4'hF);
            if (prev_ack && wbs_ack_o) ack_dbl++;
            prev_ack = wbs_ack_o;
            if (!wbs_ack_o && wbs_dat_o != 32'd0) dato_bad++;
            if (stall_left > 0) begin
                if (ss_tvalid) begin
                    stall_started = 1'b1;
                    stall_seen++;
                    if (ss_tdata != 32'd1) stall_bad++;
                    if (mem_en && mem_we == 4'h0) stall_reads++;
                    stall_left--;
                end else if (stall_started) begin
                    stall_gap++;
                end
            end
            @(posedge clk);
            #1;
            if (m_en) begin
                if (m_we == 4'hF) begin
                    bram[m_addr] = m_wd;
                    wr_seen++;
                end else begin
                    mem_rdata = bram[m_addr];
                    rd_seen++;
                    rd_addr_q.push_back(m_addr);
                end
            end
            if (m_fire && fir_q.size() > 0) void'(fir_q.pop_front());
            if (s_fire) begin
                ss_log.push_back(s_data);
                ss_last_log.push_back(s_last);
                fir_q.push_back({s_last || (res_idx == bad_idx), s_data << 1});
                res_idx++;
            end
            ss_tready = (stall_left == 0);
            sm_tvalid = (fir_q.size() > 0);
            if (sm_tvalid) {sm_tlast, sm_tdata} = fir_q[0];
            else {sm_tlast, sm_tdata} = 33'd0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_write(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk);
        #2;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d;
        @(posedge clk);
        #2;
        chk("wb_write_ack", {31'd0, wbs_ack_o}, 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [7:0] a, output logic [31:0] d);
        @(posedge clk);
        #2;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
        @(posedge clk);
        #2;
        chk("wb_read_ack", {31'd0, wbs_ack_o}, 32'd1);
        d = wbs_dat_o;
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic clear_logs();
        ss_log.delete();
        ss_last_log.delete();
        rd_addr_q.delete();
        rd_seen = 0; wr_seen = 0; busy_cycles = 0; en_cnt = 0; ssv_cnt = 0;
        wr_then_rd = 0; res_idx = 0;
    endtask

    task automatic setup(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len);
        wb_write(8'h08, src);
        wb_write(8'h0C, dst);
        wb_write(8'h04, len);
        wb_write(8'h00, 32'h2);
    endtask

    initial begin : main
        logic [31:0] rd;
        logic [3:0]  lv;
        int          n;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0;
        for (int i = 0; i < 4096; i++) bram[i] = 32'd0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_ss_tvalid", {31'd0, ss_tvalid}, 32'd0);
        chk("rst_sm_tready", {31'd0, sm_tready}, 32'd0);
        chk("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
        chk("rst_dat", wbs_dat_o, 32'd0);
        rst = 1'b0;
        wb_read(8'h00, rd);
        chk("rst_ctrl", rd, 32'h4);

        // 1: basic four-sample run
        for (int i = 0; i < 4; i++) bram[i] = i + 1;
        setup(32'h000, 32'h100, 32'd4);
        wb_read(8'h04, rd);
        chk("t1_len_rb", rd, 32'd4);
        clear_logs();
        wb_write(8'h00, 32'h1);
        wait_idle("t1_idle");
        chk("t1_ss_cnt", ss_log.size(), 32'd4);
        lv = '0;
        for (int i = 0; i < 4; i++) begin
            chk("t1_ss_data", ss_log[i], i + 1);
            lv[i] = ss_last_log[i];
        end
        chk("t1_ss_last", {28'd0, lv}, 32'h8);
        for (int i = 0; i < 4; i++) chk("t1_bram", bram[12'h100 + i], 2 * (i + 1));
        wb_read(8'h00, rd);
        chk("t1_ctrl", rd, 32'h6);
        wb_read(8'h10, rd);
        chk("t1_wrcnt", rd, 32'd4);

        // 2: zero length goes straight through FINISH
        setup(32'h000, 32'h100, 32'd0);
        wb_read(8'h00, rd);
        chk("t2_ctrl_pre", rd, 32'h4);
        clear_logs();
        wb_write(8'h00, 32'h1);
        repeat (5) @(posedge clk);
        #2;
        chk("t2_busy_cycles", busy_cycles, 32'd1);
        chk("t2_mem_en", en_cnt, 32'd0);
        chk("t2_ss_tvalid", ssv_cnt, 32'd0);
        wb_read(8'h00, rd);
        chk("t2_ctrl", rd, 32'h6);

        // 3: consumer holds off the first sample for ten cycles
        bram[12'h010] = 32'd1; bram[12'h011] = 32'd5; bram[12'h012] = 32'd9;
        setup(32'h010, 32'h110, 32'd3);
        clear_logs();
        stall_seen = 0; stall_bad = 0; stall_reads = 0; stall_gap = 0; stall_started = 1'b0;
        stall_left = 10;
        @(posedge clk);
        #2;
        wb_write(8'h00, 32'h1);
        wait_idle("t3_idle");
        chk("t3_stall_seen", stall_seen, 32'd10);
        chk("t3_stall_data", stall_bad, 32'd0);
        chk("t3_stall_gap", stall_gap, 32'd0);
        chk("t3_stall_reads", stall_reads, 32'd0);
        chk("t3_ss_cnt", ss_log.size(), 32'd3);
        chk("t3_ss1", ss_log[1], 32'd5);
        chk("t3_bram0", bram[12'h110], 32'd2);
        chk("t3_bram2", bram[12'h112], 32'd18);

        // 4: write/read contention over eight samples, source wrapping past 0xFFF
        for (int i = 0; i < 8; i++) bram[(12'hFFC + i) & 12'hFFF] = 7 + 3 * i;
        setup(32'hFFC, 32'h120, 32'd8);
        clear_logs();
        wb_write(8'h00, 32'h1);
        wait_idle("t4_idle");
        chk("t4_reads", rd_seen, 32'd8);
        chk("t4_writes", wr_seen, 32'd8);
        chk("t4_contention_seen", {31'd0, wr_then_rd > 0}, 32'd1);
        chk("t4_ss_cnt", ss_log.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("t4_rd_addr", {20'd0, rd_addr_q[i]}, (32'hFFC + i) & 32'hFFF);
            chk("t4_bram", bram[12'h120 + i], 2 * (7 + 3 * i));
        end

        // 5: early tlast on the second result
        bram[12'h030] = 32'd10; bram[12'h031] = 32'd20; bram[12'h032] = 32'd30;
        setup(32'h030, 32'h130, 32'd3);
        clear_logs();
        bad_idx = 1;
        wb_write(8'h00, 32'h1);
        wait_idle("t5_idle");
        bad_idx = -1;
        wb_read(8'h00, rd);
        chk("t5_ctrl_err", rd, 32'hE);
        wb_read(8'h10, rd);
        chk("t5_wrcnt", rd, 32'd3);
        chk("t5_bram1", bram[12'h131], 32'd40);
        chk("t5_bram2", bram[12'h132], 32'd60);
        wb_write(8'h00, 32'h8);
        wb_read(8'h00, rd);
        chk("t5_ctrl_clr", rd, 32'h6);

        // 6: abort mid-run, then a clean short run
        for (int i = 0; i < 6; i++) bram[12'h040 + i] = 32'h60 + i;
        setup(32'h040, 32'h140, 32'd6);
        clear_logs();
        wb_write(8'h00, 32'h1);
        n = 0;
        while (ss_log.size() < 2 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("t6_two_samples", {31'd0, ss_log.size() >= 2}, 32'd1);
        wb_write(8'h00, 32'h10);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_ss_tvalid", {31'd0, ss_tvalid}, 32'd0);
        chk("t6_sm_tready", {31'd0, sm_tready}, 32'd0);
        repeat (3) @(posedge clk);
        #2;
        fir_q.delete();
        wb_read(8'h00, rd);
        chk("t6_ctrl_abort", rd, 32'h4);
        bram[12'h050] = 32'h11; bram[12'h051] = 32'h22;
        setup(32'h050, 32'h150, 32'd2);
        clear_logs();
        wb_write(8'h00, 32'h1);
        wait_idle("t6_idle");
        chk("t6_ss_cnt", ss_log.size(), 32'd2);
        chk("t6_ss0", ss_log[0], 32'h11);
        chk("t6_rd_addr0", {20'd0, rd_addr_q[0]}, 32'h050);
        chk("t6_bram0", bram[12'h150], 32'h22);
        chk("t6_bram1", bram[12'h151], 32'h44);
        wb_read(8'h10, rd);
        chk("t6_wrcnt", rd, 32'd2);
        wb_read(8'h00, rd);
        chk("t6_ctrl", rd, 32'h6);

        wb_read(8'h14, rd);
        chk("unmapped_rd", rd, 32'd0);
        chk("ack_never_twice", ack_dbl, 32'd0);
        chk("dat_zero_without_ack", dato_bad, 32'd0);
        chk("mem_we_legal", we_bad, 32'd0);
        chk("sm_fire_writes", fire_bad, 32'd0);

        // reset from a DONE state clears status and registers
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        wb_read(8'h00, rd);
        chk("rst2_ctrl", rd, 32'h4);
        wb_read(8'h04, rd);
        chk("rst2_len", rd, 32'd0);
        wb_read(8'h10, rd);
        chk("rst2_wrcnt", rd, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
